// File: rtl/xc_clb_pkg.sv
// xc_clb_pkg: derived sizes, slice field offsets and slice flag layout for xc_clb_gen
package xc_clb_pkg;
  localparam int INIT_OFS = 0;
  typedef struct packed {
    logic ce_use;
    logic ff_init;
    logic out_q;
  } slice_flags_t;
  function automatic int selw_f(int num_in, int num_lut);
    return $clog2(num_in + num_lut);
  endfunction
  function automatic int slice_w_f(int lut_k, int selw);
    return 2**lut_k + lut_k * selw + 3;
  endfunction
  function automatic int cfg_len_f(int num_lut, int slice_w);
    return num_lut * slice_w;
  endfunction
  function automatic int sel_ofs_f(int lut_k);
    return 2**lut_k;
  endfunction
  function automatic int outq_ofs_f(int lut_k, int selw);
    return 2**lut_k + lut_k * selw;
  endfunction
  function automatic int ffinit_ofs_f(int lut_k, int selw);
    return outq_ofs_f(lut_k, selw) + 1;
  endfunction
  function automatic int ceuse_ofs_f(int lut_k, int selw);
    return outq_ofs_f(lut_k, selw) + 2;
  endfunction
endpackage

// File: rtl/xc_clb_slice.sv
// xc_clb_slice: one routed LUT feeding a flip-flop, with registered/combinational output select
module xc_clb_slice
  import xc_clb_pkg::*;
#(
  parameter int LUT_K = 4,
  parameter int NUM_IN = 4,
  parameter int NUM_LUT = 2,
  parameter int SELW = selw_f(NUM_IN, NUM_LUT),
  parameter int SLICE_W = slice_w_f(LUT_K, SELW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               out_en,
  input  logic               ce,
  input  logic [NUM_IN-1:0]  i,
  input  logic [NUM_LUT-1:0] q_all,
  input  logic [SLICE_W-1:0] cfg,
  output logic               q,
  output logic               o
);
  localparam int OUTQ_OFS = outq_ofs_f(LUT_K, SELW);
  logic [2**LUT_K-1:0] init;
  logic [2**SELW-1:0] src;
  logic [LUT_K-1:0] pin;
  slice_flags_t flags;
  logic l;
  assign init = cfg[INIT_OFS +: 2**LUT_K];
  assign flags = cfg[OUTQ_OFS +: 3];
  // pin sources: block inputs, then registered slice feedback, unused codes read 0
  always_comb begin
    src = '0;
    src[NUM_IN-1:0] = i;
    src[NUM_IN +: NUM_LUT] = q_all;
  end
  for (genvar p = 0; p < LUT_K; p++) begin : g_pin
    assign pin[p] = src[cfg[sel_ofs_f(LUT_K) + p*SELW +: SELW]];
  end
  assign l = init[pin];
  // flop follows its init bit while reset, unconfigured or shifting
  always_ff @(posedge clk)
    q <= (rst || load) ? flags.ff_init : (ce || !flags.ce_use) ? l : q;
  assign o = out_en & (flags.out_q ? q : l);
endmodule

// File: rtl/xc_clb_gen.sv
// xc_clb_gen: configurable logic block with serial config chain; XC_CLB_CE_EN adds the CE port
module xc_clb_gen
  import xc_clb_pkg::*;
#(
  parameter int LUT_K = 4,
  parameter int NUM_LUT = 2,
  parameter int NUM_IN = 4
) (
  input  logic               K,
  input  logic               R,
  input  logic [NUM_IN-1:0]  I,
  input  logic               CFG_EN,
  input  logic               CFG_D,
  output logic               CFG_Q,
  output logic               CFG_DONE,
  output logic [NUM_LUT-1:0] O
`ifdef XC_CLB_CE_EN
  ,
  input  logic               CE
`endif
);
  localparam int SELW = selw_f(NUM_IN, NUM_LUT);
  localparam int SLICE_W = slice_w_f(LUT_K, SELW);
  localparam int CFG_LEN = cfg_len_f(NUM_LUT, SLICE_W);
  localparam int CW = $clog2(CFG_LEN + 1);
  logic [CFG_LEN-1:0] cfg;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_LUT-1:0] q;
  logic ce;
`ifdef XC_CLB_CE_EN
  assign ce = CE;
`else
  assign ce = 1'b1;
`endif
  assign cnt_n = R ? '0 : (CFG_EN && cnt != CW'(CFG_LEN)) ? cnt + CW'(1) : cnt;
  assign CFG_Q = cfg[CFG_LEN-1];
  // config memory survives reset; reset only blocks the shift
  always_ff @(posedge K)
    if (!R && CFG_EN) cfg <= {cfg[CFG_LEN-2:0], CFG_D};
  // shift counter saturates at a full load; done is registered alongside
  always_ff @(posedge K) begin
    cnt <= cnt_n;
    CFG_DONE <= (cnt_n == CW'(CFG_LEN));
  end
  for (genvar j = 0; j < NUM_LUT; j++) begin : g_slice
    xc_clb_slice #(
      .LUT_K(LUT_K),
      .NUM_IN(NUM_IN),
      .NUM_LUT(NUM_LUT)
    ) u_slice (
      .clk(K),
      .rst(R),
      .load(!CFG_DONE || CFG_EN),
      .out_en(CFG_DONE && !CFG_EN),
      .ce(ce),
      .i(I),
      .q_all(q),
      .cfg(cfg[j*SLICE_W +: SLICE_W]),
      .q(q[j]),
      .o(O[j])
    );
  end
endmodule

// File: tb/tb_xc_clb_gen.sv
// tb_xc_clb_gen: directed and random checks of xc_clb_gen against a behavioural model
module tb_xc_clb_gen;
  localparam int LK = 4, NL = 2, NI = 4, SW = 3, SLW = 31, LEN = 62;
  localparam int OQ = 28, FI = 29, CU = 30;
  logic K = 1'b0;
  logic R = 1'b0, CFG_EN = 1'b0, CFG_D = 1'b0, ce_v = 1'b1;
  logic [NI-1:0] I = '0;
  logic CFG_Q, CFG_DONE;
  logic [NL-1:0] O;
  logic [LEN-1:0] m_cfg = '0, m_known = '0, tcfg = '0;
  logic [NL-1:0] m_q = '0;
  int m_cnt = 0;
  logic m_done = 1'b0;
  bit chk = 1'b0;
  int checks = 0, errors = 0;
  logic prev;

  always #5 K = ~K;

  xc_clb_gen dut (
    .K(K), .R(R), .I(I), .CFG_EN(CFG_EN), .CFG_D(CFG_D),
    .CFG_Q(CFG_Q), .CFG_DONE(CFG_DONE), .O(O)
`ifdef XC_CLB_CE_EN
    , .CE(ce_v)
`endif
  );

  function automatic logic bitf(int j, int ofs);
    return m_cfg[j*SLW + ofs];
  endfunction

  function automatic logic lut(int j);
    int idx, s;
    logic v;
    idx = 0;
    for (int p = 0; p < LK; p++) begin
      s = 0;
      for (int b = 0; b < SW; b++) s += int'(bitf(j, 16 + p*SW + b)) << b;
      v = (s < NI) ? I[s] : (s < NI + NL) ? m_q[s-NI] : 1'b0;
      idx += int'(v) << p;
    end
    return bitf(j, idx);
  endfunction

  function automatic logic ce_ok(int j);
`ifdef XC_CLB_CE_EN
    return ce_v | !bitf(j, CU);
`else
    return (j >= 0);
`endif
  endfunction

  task automatic step(input logic r, input logic en, input logic d, input logic [NI-1:0] iv);
    logic [NL-1:0] eo, nq;
    R = r; CFG_EN = en; CFG_D = d; I = iv;
    #1;
    for (int j = 0; j < NL; j++) eo[j] = m_done & !en & (bitf(j, OQ) ? m_q[j] : lut(j));
    if (chk) begin
      checks++;
      assert (O === eo) else begin errors++; $error("FAIL out O=%b exp=%b t=%0t", O, eo, $time); end
      checks++;
      assert (CFG_DONE === m_done) else begin errors++; $error("FAIL done got=%b exp=%b t=%0t", CFG_DONE, m_done, $time); end
      if (m_known[LEN-1]) begin
        checks++;
        assert (CFG_Q === m_cfg[LEN-1]) else begin errors++; $error("FAIL cfg_q got=%b exp=%b t=%0t", CFG_Q, m_cfg[LEN-1], $time); end
      end
    end
    for (int j = 0; j < NL; j++) nq[j] = (r || !m_done || en) ? bitf(j, FI) : ce_ok(j) ? lut(j) : m_q[j];
    @(posedge K);
    m_q = nq;
    if (!r && en) begin
      m_cfg = {m_cfg[LEN-2:0], d};
      m_known = {m_known[LEN-2:0], 1'b1};
    end
    m_cnt = r ? 0 : (en && m_cnt < LEN) ? m_cnt + 1 : m_cnt;
    m_done = (m_cnt == LEN);
    @(negedge K);
  endtask

  task automatic set_slice(input int j, input logic [15:0] init, input logic [11:0] sel,
                           input logic oq, input logic fi, input logic cu);
    tcfg[j*SLW +: 16] = init;
    tcfg[j*SLW + 16 +: 12] = sel;
    tcfg[j*SLW + OQ] = oq;
    tcfg[j*SLW + FI] = fi;
    tcfg[j*SLW + CU] = cu;
  endtask

  task automatic load(input logic [NI-1:0] iv);
    for (int b = LEN - 1; b >= 0; b--) step(1'b0, 1'b1, tcfg[b], iv);
  endtask

  initial begin
    @(negedge K);
    for (int n = 0; n < LEN; n++) step(1'b0, 1'b1, 1'($urandom), '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    checks++;
    assert (CFG_DONE === 1'b0 && O === 2'b00) else begin errors++; $error("FAIL reset done=%b O=%b exp 0/00", CFG_DONE, O); end
    set_slice(0, 16'h8888, {3'd7, 3'd7, 3'd1, 3'd0}, 1'b0, 1'b0, 1'b0);
    set_slice(1, 16'h5555, {3'd7, 3'd7, 3'd7, 3'd5}, 1'b1, 1'b0, 1'b0);
    for (int b = LEN - 1; b >= 1; b--) step(1'b0, 1'b1, tcfg[b], 4'b0011);
    checks++;
    assert (CFG_DONE === 1'b0) else begin errors++; $error("FAIL done61 got=%b exp=0", CFG_DONE); end
    step(1'b0, 1'b1, tcfg[0], 4'b0011);
    checks++;
    assert (CFG_DONE === 1'b1) else begin errors++; $error("FAIL done62 got=%b exp=1", CFG_DONE); end
    step(1'b0, 1'b0, 1'b0, 4'b0011);
    checks++;
    assert (O[0] === 1'b1) else begin errors++; $error("FAIL and11 got=%b exp=1", O[0]); end
    step(1'b0, 1'b0, 1'b0, 4'b0001);
    checks++;
    assert (O[0] === 1'b0) else begin errors++; $error("FAIL and01 got=%b exp=0", O[0]); end
    prev = O[1];
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b0, 1'b0, 4'($urandom));
      checks++;
      assert (O[1] === ~prev) else begin errors++; $error("FAIL toggle got=%b exp=%b", O[1], ~prev); end
      prev = O[1];
    end
    step(1'b1, 1'b0, 1'b0, 4'b0011);
    step(1'b0, 1'b0, 1'b0, 4'b0011);
    checks++;
    assert (O === 2'b00 && CFG_DONE === 1'b0) else begin errors++; $error("FAIL rst_mid O=%b done=%b exp 00/0", O, CFG_DONE); end
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 4'($urandom));
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'($urandom), 4'($urandom));
    load(4'b0011);
    step(1'b0, 1'b0, 1'b0, 4'b0011);
    checks++;
    assert (O[0] === 1'b1 && CFG_DONE === 1'b1) else begin errors++; $error("FAIL reload O0=%b done=%b exp 1/1", O[0], CFG_DONE); end
    for (int n = 0; n < 20; n++) step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
    for (int n = 0; n < 200; n++)
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom), 4'($urandom));
    for (int n = 0; n < LEN; n++) step(1'b0, 1'b1, 1'($urandom), 4'($urandom));
    for (int n = 0; n < 30; n++) step(1'b0, 1'b0, 1'b0, 4'($urandom));
`ifdef XC_CLB_CE_EN
    set_slice(1, 16'h5555, {3'd7, 3'd7, 3'd7, 3'd5}, 1'b1, 1'b0, 1'b1);
    load(4'b0000);
    step(1'b0, 1'b0, 1'b0, '0);
    ce_v = 1'b0;
    prev = O[1];
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      checks++;
      assert (O[1] === prev) else begin errors++; $error("FAIL ce_hold got=%b exp=%b", O[1], prev); end
    end
    ce_v = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      checks++;
      assert (O[1] === ~prev) else begin errors++; $error("FAIL ce_run got=%b exp=%b", O[1], ~prev); end
      prev = O[1];
    end
    set_slice(1, 16'h5555, {3'd7, 3'd7, 3'd7, 3'd5}, 1'b1, 1'b0, 1'b0);
    load(4'b0000);
    step(1'b0, 1'b0, 1'b0, '0);
    ce_v = 1'b0;
    for (int n = 0; n < 20; n++) step(1'b0, 1'($urandom_range(0, 5) == 0), 1'($urandom), 4'($urandom));
    ce_v = 1'b1;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xc_clb_gen.md
Name: xc_clb_gen

Overview:
Parametrised next-generation configurable logic block for the XC-family primitive library.
- NUM_LUT slices, each one LUT_K-input LUT feeding one flip-flop.
- Each LUT pin is routed from block inputs or from registered slice feedback.
- Configuration is loaded serially through a daisy-chainable shift register, so configuration is modelled as state.
- Used by the architecture simulation models in place of fixed-mode parameter strings.

Parameters:
LUT_K, 4, inputs per LUT (2..6)
NUM_LUT, 2, slices/outputs per block (1..8)
NUM_IN, 4, general block inputs
Derived (package functions, not overridable): SELW=clog2(NUM_IN+NUM_LUT); SLICE_W=2**LUT_K+LUT_K*SELW+3; CFG_LEN=NUM_LUT*SLICE_W (62 at defaults)

Ports:
K  in  1  clock, rising edge
R  in  1  synchronous active-high reset
I  in  NUM_IN  general logic inputs
CFG_EN  in  1  configuration shift enable
CFG_D  in  1  serial configuration data in
CFG_Q  out  1  serial configuration data out (chain to next block)
CFG_DONE  out  1  configuration complete
O  out  NUM_LUT  slice outputs
CE  in  1  clock enable (only with XC_CLB_CE_EN)

Behaviour:
- One clock K. Reset R is synchronous and active-high. Everything updates on the rising edge of K.
- Config memory cfg[CFG_LEN-1:0]:
  - Slice j occupies bits [j*SLICE_W +: SLICE_W].
  - Slice field order from LSB: INIT[2**LUT_K], SEL[LUT_K*SELW] (pin p at p*SELW), OUT_Q, FF_INIT, CE_USE.
- Shift, when CFG_EN=1 and R=0: cfg <= {cfg[CFG_LEN-2:0], CFG_D}. The first bit shifted in ends up in the MSB.
- CFG_Q = cfg[CFG_LEN-1], combinational from the register.
- cfg is NOT cleared by R; its power-up content is don't-care.
- Counter cnt, width clog2(CFG_LEN+1):
  - R clears it.
  - Each shift cycle increments it; it saturates at CFG_LEN.
  - CFG_DONE = (cnt==CFG_LEN), registered.
- R has priority over CFG_EN: in an R cycle there is no shift and cnt=0.
- Pin source for SEL value s:
  - s<NUM_IN → I[s].
  - NUM_IN<=s<NUM_IN+NUM_LUT → Q[s-NUM_IN], the registered value, so no combinational loops.
  - Otherwise → 0.
- LUT output L[j] = INIT[{pinK-1..pin0}], with pin0 as the LSB.
- Flip-flop Q[j], in priority order:
  1. If R, or !CFG_DONE, or CFG_EN: Q <= FF_INIT. Q continuously tracks the config bit and holds through shifting.
  2. Else if enabled: Q <= L[j].
  3. Else hold.
- Output O[j] = CFG_DONE & !CFG_EN & (OUT_Q ? Q[j] : L[j]). O is forced to 0 while unconfigured or shifting.
- Reset values: CFG_DONE=0, O=0, Q=FF_INIT (current config). CFG_Q reflects the retained cfg.
- Latency:
  - L path: combinational.
  - Q path: 1 cycle.
  - After the final config bit, CFG_DONE rises on that same edge, and outputs are valid once CFG_EN is deasserted.
- Reconfiguration after DONE: CFG_DONE stays 1 (cnt saturated), but outputs are forced to 0 while shifting. A partial reload therefore leaves a mixed configuration, which is legal.
- Reset mid-load: cnt=0, shifting resumes without loss of already-shifted bits, and DONE needs a full CFG_LEN further shifts.

Optional Feature:
XC_CLB_CE_EN
- Defined: port CE exists. Slice j is enabled when (CE | !CE_USE[j]).
- Undefined: no CE port. CE_USE is stored but ignored, and all slices are always enabled.
- Config length is identical in both builds.

Decomposition:
- Package xc_clb_pkg holds:
  - clog2-based functions for SELW, SLICE_W, CFG_LEN.
  - Field-offset constants/functions (INIT_OFS=0, SEL_OFS=2**LUT_K, OUTQ_OFS, FFINIT_OFS, CEUSE_OFS).
  - Typedef for the slice config struct.
- Sub-module xc_clb_slice: one LUT plus pin muxes plus FF plus output mux, taking its SLICE_W config slice. Instantiate it NUM_LUT times in a generate loop.
- The config shift register and counter stay in the top level.

Test Plan:
1. Reset then shift 61 bits → CFG_DONE=0, O=0. The 62nd shift → CFG_DONE=1 on that edge; CFG_Q emits the first bit 62 cycles after it entered.
2. Slice0: INIT=16'h8888, SEL pins=I0,I1, OUT_Q=0 → O[0]=I0&I1 combinationally. I=4'b0011 → O[0]=1; I=4'b0001 → 0.
3. Slice1: INIT=16'h5555 (not pin0), pin0=Q1 (s=5), OUT_Q=1, FF_INIT=0 → O[1] toggles 0,1,0,1 on successive edges after CFG_EN drops.
4. Assert R for 1 cycle mid-operation → O=0 next cycle, Q=FF_INIT, CFG_DONE=0. No further shifting → O stays 0 and the cfg contents are unchanged (verify via CFG_Q after 62 more shifts).
5. R and CFG_EN high together for 3 cycles → cnt=0 and no shift (CFG_Q unchanged).
6. With XC_CLB_CE_EN, CE_USE=1 on the toggling slice: CE=0 for 3 cycles → O[1] holds. CE=1 → resumes toggling. With CE_USE=0 it ignores CE.
